// File: rtl/niosiie_ram_dout_if.sv
// Avalon-MM slave bus bundle for the NIOSIIe RAM write port.
// The master side is the CPU. The slave side is the RAM write-port block.
interface niosiie_ram_dout_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/niosiie_ram_dout.sv
// CPU-to-NES RAM byte writer with timed setup/strobe/hold out_we; readdata lags address by 1 clk.
// Never stalls the bus: writes arriving while a cycle is in flight are dropped and flag overrun.
module niosiie_ram_dout #(
  parameter int ADDR_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  niosiie_ram_dout_if.slave    bus,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [7:0]           out_data,
  output logic                 out_we
);

  localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_P = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [7:0]         data_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               ovr_q;
  logic               go_q;
  logic               addr_inc;
  logic [31:0]        rd_nxt;

  logic busy, wr, wr_data, wr_addr, wr_ctrl, wr_go;
  logic start, ovr_set, ovr_clr;
  logic unused_wd;

  assign busy    = (state_q != IDLE);
  assign wr      = bus.chipselect && !bus.write_n;
  assign wr_data = wr && (bus.address == 2'd0);
  assign wr_addr = wr && (bus.address == 2'd1);
  assign wr_ctrl = wr && (bus.address == 2'd2);
  assign wr_go   = wr && (bus.address == 2'd3);

  assign start   = !busy && ((wr_ctrl && bus.writedata[0]) || wr_go);
  assign ovr_set = busy && (wr_data || wr_addr || wr_go || (wr_ctrl && bus.writedata[0]));
  assign ovr_clr = wr_ctrl && bus.writedata[1];

  assign unused_wd = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // The counter is reloaded with (phase length - 1) on every phase entry.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    addr_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          cnt_nxt   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_nxt = STROBE;
          cnt_nxt   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_nxt = IDLE;
          addr_inc  = go_q;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      addr_q <= '0;
      ovr_q  <= 1'b0;
      go_q   <= 1'b0;
    end else begin
      if (!busy && (wr_data || wr_go))
        data_q <= bus.writedata[7:0];
      if (!busy && wr_addr)
        addr_q <= bus.writedata[ADDR_W-1:0];
      else if (addr_inc)
        addr_q <= addr_q + 1'b1;
      // A dropped start in the same write as a clear still counts as overrun.
      if (ovr_set)
        ovr_q <= 1'b1;
      else if (ovr_clr)
        ovr_q <= 1'b0;
      if (start)
        go_q <= wr_go;
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      2'd0:    rd_nxt[7:0]        = data_q;
      2'd1:    rd_nxt[ADDR_W-1:0] = addr_q;
      2'd2:    rd_nxt[1:0]        = {ovr_q, busy};
      default: rd_nxt             = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      bus.readdata <= '0;
    else
      bus.readdata <= rd_nxt;
  end

  assign out_addr = addr_q;
  assign out_data = data_q;
  assign out_we   = (state_q == STROBE);

endmodule

// File: tb/tb_niosiie_ram_dout.sv
// Randomized bench for niosiie_ram_dout against a cycle-count reference model.
module tb_niosiie_ram_dout;
  localparam int S = 1, T = 2, H = 1, TOT = S + T + H;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  niosiie_ram_dout_if b1();
  niosiie_ram_dout_if b2();
  logic [15:0] out_addr1, out_addr2;
  logic [7:0]  out_data1, out_data2;
  logic        out_we1, out_we2;

  niosiie_ram_dout dut (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave),
    .out_addr(out_addr1), .out_data(out_data1), .out_we(out_we1)
  );

  niosiie_ram_dout #(.ADDR_W(16), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave),
    .out_addr(out_addr2), .out_data(out_data2), .out_we(out_we2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers plus "cycles left in the current write cycle".
  logic [7:0]  m_data;
  logic [15:0] m_addr;
  bit          m_ovr;
  bit          m_go;
  int          m_rem;

  task automatic model_reset();
    m_data = '0; m_addr = '0; m_ovr = 0; m_go = 0; m_rem = 0;
  endtask

  // Drive one bus cycle, clock it, then compare every DUT output with the model.
  task automatic step(input bit cs, input logic [1:0] adr, input bit wn, input logic [31:0] wd);
    bit busy, wr, st;
    logic [31:0] rd_exp;
    int el;
    b1.chipselect = cs; b1.address = adr; b1.write_n = wn; b1.writedata = wd;
    busy = (m_rem > 0);
    case (adr)
      2'd0:    rd_exp = {24'h0, m_data};
      2'd1:    rd_exp = {16'h0, m_addr};
      2'd2:    rd_exp = {30'h0, m_ovr, busy};
      default: rd_exp = 32'h0;
    endcase
    wr = cs && !wn;
    st = 0;
    if (wr) begin
      case (adr)
        2'd0: if (busy) m_ovr = 1; else m_data = wd[7:0];
        2'd1: if (busy) m_ovr = 1; else m_addr = wd[15:0];
        2'd2: begin
          if (busy && wd[0]) m_ovr = 1;
          else if (wd[1]) m_ovr = 0;
          if (!busy && wd[0]) begin st = 1; m_go = 0; end
        end
        default: if (busy) m_ovr = 1; else begin m_data = wd[7:0]; st = 1; m_go = 1; end
      endcase
    end
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_go) m_addr = m_addr + 16'd1;
    end
    if (st) m_rem = TOT;
    @(posedge clk);
    #1;
    el = TOT - m_rem;
    chk("out_we",   {31'h0, out_we1}, {31'h0, (m_rem > 0 && el >= S && el < S + T)});
    chk("out_addr", {16'h0, out_addr1}, {16'h0, m_addr});
    chk("out_data", {24'h0, out_data1}, {24'h0, m_data});
    chk("readdata", b1.readdata, rd_exp);
  endtask

  task automatic idle(input int n, input logic [1:0] adr);
    for (int i = 0; i < n; i++) step(0, adr, 1, 32'h0);
  endtask

  initial begin
    int j;
    logic [1:0] ra;
    logic [31:0] rw;
    b1.chipselect = 0; b1.address = 0; b1.write_n = 1; b1.writedata = 0;
    b2.chipselect = 0; b2.address = 2; b2.write_n = 1; b2.writedata = 0;
    model_reset();
    #12;
    chk("rst_out_we",   {31'h0, out_we1}, 32'h0);
    chk("rst_out_addr", {16'h0, out_addr1}, 32'h0);
    chk("rst_out_data", {24'h0, out_data1}, 32'h0);
    chk("rst_readdata", b1.readdata, 32'h0);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    // Single CTRL-started write.
    step(1, 2'd1, 0, 32'h0123);
    step(1, 2'd0, 0, 32'hA5);
    step(1, 2'd2, 0, 32'h1);
    idle(6, 2'd2);

    // DATA_GO streaming across the address wrap.
    step(1, 2'd1, 0, 32'hFFFE);
    step(1, 2'd3, 0, 32'h11); idle(5, 2'd2);
    step(1, 2'd3, 0, 32'h22); idle(5, 2'd2);
    step(1, 2'd3, 0, 32'h33); idle(5, 2'd1);

    // Overrun: write during busy, then clear.
    step(1, 2'd3, 0, 32'h44);
    step(1, 2'd0, 0, 32'h55);
    idle(5, 2'd2);
    idle(1, 2'd0);
    step(1, 2'd2, 0, 32'h3);
    step(1, 2'd2, 0, 32'h2);
    idle(5, 2'd2);
    step(1, 2'd2, 0, 32'h2);
    idle(2, 2'd2);

    // Readback of ADDR and DATA_GO offset.
    step(1, 2'd1, 0, 32'hBEEF);
    idle(2, 2'd1);
    idle(2, 2'd3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      ra = 2'($urandom_range(0, 3));
      rw = $urandom;
      step(($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 2) != 0), rw);
    end
    idle(6, 2'd2);

    // Asynchronous reset in the middle of STROBE.
    step(1, 2'd2, 0, 32'h1);
    idle(1, 2'd1);
    chk("strobe_before_rst", {31'h0, out_we1}, 32'h1);
    reset_n = 0;
    #2;
    chk("arst_out_we",   {31'h0, out_we1}, 32'h0);
    chk("arst_out_addr", {16'h0, out_addr1}, 32'h0);
    chk("arst_out_data", {24'h0, out_data1}, 32'h0);
    chk("arst_readdata", b1.readdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    idle(2, 2'd2);
    idle(2, 2'd1);

    // Non-default phase lengths: 3 setup, 1 strobe, 2 hold.
    b2.chipselect = 1; b2.address = 2; b2.write_n = 0; b2.writedata = 32'h1;
    @(posedge clk); #1;
    b2.chipselect = 0; b2.write_n = 1; b2.writedata = 0;
    for (j = 0; j < 9; j++) begin
      chk("p2_out_we", {31'h0, out_we2}, {31'h0, (j == 3)});
      chk("p2_busy",   b2.readdata, {31'h0, (j >= 1 && j <= 6)});
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
